// File: rtl/qdma_descriptor_mux_n_pkg.sv
// Shared constants for the N-channel descriptor mux.
// Register offsets, version word and index-width helper.
package qdma_desc_mux_pkg;

   localparam logic [31:0] OFF_CH_EN    = 32'h00;
   localparam logic [31:0] OFF_LAST     = 32'h04;
   localparam logic [31:0] OFF_CNT_CLR  = 32'h08;
   localparam logic [31:0] OFF_VERSION  = 32'h0C;
   localparam logic [31:0] OFF_CNT      = 32'h40;
   localparam logic [31:0] VERSION_BASE = 32'h0002_0000;

   function automatic int chan_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/qdma_descriptor_mux_n_rr_arbiter.sv
// Round-robin arbiter: first requester after the last grant wins.
// Produces a one-hot grant plus its binary index.
module rr_arbiter_n
   import qdma_desc_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IW     = chan_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [IW-1:0]     i_last,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [IW-1:0]     o_idx,
   output logic              o_any
);

   int w_c;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_c   = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_c = (int'(i_last) + k) % NUM_CH;
         if (!o_any && i_req[w_c]) begin
            o_any      = 1'b1;
            o_gnt[w_c] = 1'b1;
            o_idx      = IW'(w_c);
         end
      end
   end

endmodule

// File: rtl/qdma_descriptor_mux_n.sv
// N-channel round-robin descriptor mux with source tagging and an
// AXI4-Lite block for enable mask, last grant and per-channel counters.
module qdma_descriptor_mux_n
   import qdma_desc_mux_pkg::*;
#(
   parameter int NUM_CH             = 4,
   parameter int DESC_W             = 128,
   parameter int CNT_W              = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 7,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   input  logic [NUM_CH-1:0]                 s_desc_valid,
   output logic [NUM_CH-1:0]                 s_desc_ready,
   input  logic [NUM_CH*DESC_W-1:0]          s_desc_data,
   output logic                              m_desc_valid,
   input  logic                              m_desc_ready,
   output logic [DESC_W-1:0]                 m_desc_data,
   output logic [chan_w(NUM_CH)-1:0]         m_desc_chan
);

   localparam int CW = chan_w(NUM_CH);
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              r_mvalid;
   logic [DESC_W-1:0] r_mdata;
   logic [CW-1:0]     r_mchan;
   logic [CW-1:0]     r_last;
   logic [NUM_CH-1:0] r_ch_en;
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic              r_bvalid;
   logic              r_rvalid;
   logic [31:0]       r_rdata;

   logic              w_free;
   logic [NUM_CH-1:0] w_req;
   logic [NUM_CH-1:0] w_gnt;
   logic [CW-1:0]     w_gidx;
   logic              w_any;
   logic [DESC_W-1:0] w_sel;
   logic              w_wacc;
   logic              w_racc;
   logic [31:0]       w_waddr;
   logic [31:0]       w_raddr;
   logic [31:0]       w_wmask;
   logic [31:0]       w_wd;
   logic [NUM_CH-1:0] w_clr;
   logic [31:0]       w_rdata;
   logic              w_unused;

   // Ready is withheld during reset so nothing handshakes on that edge.
   assign w_free = ~r_mvalid | m_desc_ready;
   assign w_req  = s_desc_valid & r_ch_en & {NUM_CH{w_free & ~ARESET}};

   rr_arbiter_n #(
      .NUM_CH (NUM_CH),
      .IW     (CW)
   ) u_arb (
      .i_req  (w_req),
      .i_last (r_last),
      .o_gnt  (w_gnt),
      .o_idx  (w_gidx),
      .o_any  (w_any)
   );

   assign s_desc_ready = w_gnt;

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (w_gnt[i]) w_sel = s_desc_data[i*DESC_W +: DESC_W];
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_mvalid <= 1'b0;
         r_mdata  <= '0;
         r_mchan  <= '0;
         r_last   <= CW'(NUM_CH - 1);
      end else if (w_any) begin
         r_mvalid <= 1'b1;
         r_mdata  <= w_sel;
         r_mchan  <= w_gidx;
         r_last   <= w_gidx;
      end else if (m_desc_ready) begin
         r_mvalid <= 1'b0;
      end
   end

   assign m_desc_valid = r_mvalid;
   assign m_desc_data  = r_mdata;
   assign m_desc_chan  = r_mchan;

   assign w_wacc  = s_axi_awvalid & s_axi_wvalid & ~r_bvalid & ~ARESET;
   assign w_racc  = s_axi_arvalid & ~r_rvalid & ~ARESET;
   assign w_waddr = 32'({s_axi_awaddr[AW-1:2], 2'b00});
   assign w_raddr = 32'({s_axi_araddr[AW-1:2], 2'b00});

   always_comb begin
      w_wmask = '0;
      for (int b = 0; b < 4; b++)
         w_wmask[b*8 +: 8] = {8{s_axi_wstrb[b]}};
   end

   assign w_wd  = s_axi_wdata & w_wmask;
   assign w_clr = (w_wacc && w_waddr == OFF_CNT_CLR) ?
                  w_wd[NUM_CH-1:0] : '0;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_ch_en <= '1;
      end else if (w_wacc && w_waddr == OFF_CH_EN) begin
         r_ch_en <= (r_ch_en & ~w_wmask[NUM_CH-1:0]) | w_wd[NUM_CH-1:0];
      end
   end

   // Clear beats a same-cycle increment.
   always_ff @(posedge ACLK) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (ARESET || w_clr[i])
            r_cnt[i] <= '0;
         else if (w_gnt[i] && r_cnt[i] != CNT_MAX)
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET)
         r_bvalid <= 1'b0;
      else if (w_wacc)
         r_bvalid <= 1'b1;
      else if (s_axi_bready)
         r_bvalid <= 1'b0;
   end

   always_comb begin
      w_rdata = '0;
      if (w_raddr == OFF_CH_EN)
         w_rdata = 32'(r_ch_en);
      else if (w_raddr == OFF_LAST)
         w_rdata = 32'(r_last);
      else if (w_raddr == OFF_VERSION)
         w_rdata = VERSION_BASE | 32'(NUM_CH);
      for (int i = 0; i < NUM_CH; i++)
         if (w_raddr == OFF_CNT + 32'(4 * i))
            w_rdata = 32'(r_cnt[i]);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_racc) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rdata;
      end else if (s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   assign s_axi_awready = w_wacc;
   assign s_axi_wready  = w_wacc;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = w_racc;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = 2'b00;

   assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], w_wd};

endmodule

// File: tb/tb_qdma_descriptor_mux_n.sv
// Scoreboard bench for qdma_descriptor_mux_n (NUM_CH=4, CNT_W=4).
// A cycle model predicts grants, outputs and register reads.
module tb_qdma_descriptor_mux_n;

   logic         ACLK;
   logic         ARESET;
   logic [6:0]   awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [6:0]   araddr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [3:0]   want;
   logic [3:0]   sready;
   logic [511:0] sdata;
   logic         mvalid;
   logic         mready;
   logic [127:0] mdata;
   logic [1:0]   mchan;

   logic [127:0] din [4];
   int           checks;
   int           errors;
   int           seq;

   logic [129:0] desc_q [$];
   int           out_log [$];
   logic [3:0]   e_en;
   int           e_last;
   int           e_cnt [4];
   bit           e_bv;
   bit           e_rv;
   logic [31:0]  e_rd;
   bit           ar_acc;
   bit           r_done;
   bit           w_acc;
   bit           b_done;
   logic [31:0]  r_last;

   assign sdata = {din[3], din[2], din[1], din[0]};

   qdma_descriptor_mux_n #(
      .NUM_CH             (4),
      .DESC_W             (128),
      .CNT_W              (4),
      .C_S_AXI_ADDR_WIDTH (7),
      .C_S_AXI_DATA_WIDTH (32)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .s_desc_valid  (want),
      .s_desc_ready  (sready),
      .s_desc_data   (sdata),
      .m_desc_valid  (mvalid),
      .m_desc_ready  (mready),
      .m_desc_data   (mdata),
      .m_desc_chan   (mchan)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mread(input logic [6:0] a);
      logic [6:0] w;
      w = {a[6:2], 2'b00};
      case (w)
         7'h00:   return 32'(e_en);
         7'h04:   return 32'(e_last);
         7'h0C:   return 32'h0002_0004;
         7'h40:   return 32'(e_cnt[0]);
         7'h44:   return 32'(e_cnt[1]);
         7'h48:   return 32'(e_cnt[2]);
         7'h4C:   return 32'(e_cnt[3]);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      e_en   = 4'hF;
      e_last = 3;
      for (int i = 0; i < 4; i++) e_cnt[i] = 0;
      desc_q.delete();
      e_bv = 1'b0;
      e_rv = 1'b0;
   endtask

   // One clock: check at negedge, advance model, refresh data after edge.
   task automatic step();
      int          g;
      bit          free;
      bit          wacc;
      bit          racc;
      logic [31:0] rv;
      @(negedge ACLK);
      chk("m_valid", mvalid, desc_q.size() != 0);
      if (desc_q.size() != 0) begin
         chk("m_chan", mchan, desc_q[0][129:128]);
         chk("m_data", mdata, desc_q[0][127:0]);
      end
      chk("bvalid", bvalid, e_bv);
      if (e_bv) chk("bresp", bresp, 2'b00);
      chk("rvalid", rvalid, e_rv);
      if (e_rv) begin
         chk("rdata", rdata, e_rd);
         chk("rresp", rresp, 2'b00);
      end
      g    = -1;
      free = (desc_q.size() == 0) || mready;
      if (!ARESET && free)
         for (int k = 1; k <= 4; k++)
            if (g < 0 && want[(e_last + k) % 4] && e_en[(e_last + k) % 4])
               g = (e_last + k) % 4;
      chk("s_ready", sready, (g >= 0) ? 4'(1 << g) : 4'h0);
      wacc = !ARESET && awvalid && wvalid && !e_bv;
      racc = !ARESET && arvalid && !e_rv;
      chk("awready", awready, wacc);
      chk("wready", wready, wacc);
      chk("arready", arready, racc);
      rv = mread(araddr);
      if (ARESET) begin
         model_reset();
      end else begin
         if (desc_q.size() != 0 && mready) begin
            out_log.push_back(int'(desc_q[0][129:128]));
            void'(desc_q.pop_front());
         end
         if (g >= 0) begin
            desc_q.push_back({2'(g), din[g]});
            e_last = g;
            if (e_cnt[g] < 15) e_cnt[g]++;
         end
         if (e_rv && rready) begin
            e_rv   = 1'b0;
            r_done = 1'b1;
            r_last = rdata;
         end
         if (racc) begin
            e_rv   = 1'b1;
            e_rd   = rv;
            ar_acc = 1'b1;
         end
         if (e_bv && bready) begin
            e_bv   = 1'b0;
            b_done = 1'b1;
         end
         if (wacc) begin
            e_bv  = 1'b1;
            w_acc = 1'b1;
            if ({awaddr[6:2], 2'b00} == 7'h00 && wstrb[0])
               e_en = wdata[3:0];
            if ({awaddr[6:2], 2'b00} == 7'h08 && wstrb[0])
               for (int i = 0; i < 4; i++)
                  if (wdata[i]) e_cnt[i] = 0;
         end
      end
      @(posedge ACLK);
      #1;
      if (g >= 0) begin
         seq++;
         din[g] = {32'hA5A5A5A5, 32'(g), 64'(seq)};
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      int n;
      w_acc   = 1'b0;
      b_done  = 1'b0;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      n = 0;
      while (!w_acc && n < 10) begin step(); n++; end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      n = 0;
      while (!b_done && n < 10) begin step(); n++; end
      chk("wr_done", b_done, 1'b1);
   endtask

   task automatic rd(input logic [6:0] a, output logic [31:0] v);
      int n;
      ar_acc  = 1'b0;
      r_done  = 1'b0;
      araddr  = a;
      arvalid = 1'b1;
      rready  = 1'b0;
      n = 0;
      while (!ar_acc && n < 10) begin step(); n++; end
      arvalid = 1'b0;
      rready  = 1'b1;
      n = 0;
      while (!r_done && n < 10) begin step(); n++; end
      rready = 1'b0;
      chk("rd_done", r_done, 1'b1);
      v = r_last;
   endtask

   initial begin
      logic [31:0] v;
      checks  = 0;
      errors  = 0;
      seq     = 0;
      ARESET  = 1'b1;
      awaddr  = '0;
      awvalid = 1'b0;
      wdata   = '0;
      wstrb   = '0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      araddr  = '0;
      arvalid = 1'b0;
      rready  = 1'b0;
      want    = '0;
      mready  = 1'b0;
      for (int i = 0; i < 4; i++)
         din[i] = {32'hA5A5A5A5, 32'(i), 64'(0)};
      model_reset();

      repeat (3) step();
      ARESET = 1'b0;
      step();
      rd(7'h00, v); chk("rst_ch_en", v, 32'h0000000F);
      rd(7'h0C, v); chk("version", v, 32'h00020004);
      rd(7'h40, v); chk("rst_cnt0", v, 32'h0);
      rd(7'h04, v); chk("rst_last", v, 32'h3);

      // Round robin with all channels active
      out_log.delete();
      mready = 1'b1;
      want   = 4'hF;
      repeat (8) step();
      want = 4'h0;
      repeat (2) step();
      chk("rr_len", out_log.size(), 8);
      for (int k = 0; k < 8 && k < out_log.size(); k++)
         chk("rr_chan", out_log[k], k % 4);
      for (int i = 0; i < 4; i++) begin
         rd(7'(7'h40 + 4 * i), v);
         chk("rr_cnt", v, 32'd2);
      end

      // Backpressure on channel 2
      mready = 1'b0;
      want   = 4'b0100;
      repeat (6) step();
      chk("bp_chan", mchan, 2'd2);
      chk("bp_hi", mdata[127:96], 32'hA5A5A5A5);
      rd(7'h48, v); chk("bp_cnt2", v, 32'd3);
      want   = 4'h0;
      mready = 1'b1;
      repeat (2) step();

      // Enable mask 0x5
      wr(7'h00, 32'h5, 4'hF);
      out_log.delete();
      want = 4'hF;
      repeat (6) step();
      want = 4'b1010;
      step();
      chk("en_len", out_log.size(), 6);
      for (int k = 0; k < 6 && k < out_log.size(); k++)
         chk("en_chan", out_log[k], (k % 2) ? 2 : 0);
      wr(7'h00, 32'hF, 4'hF);
      want = 4'h0;
      repeat (2) step();

      // Clear and increment on the same edge
      want    = 4'b0001;
      awaddr  = 7'h08;
      wdata   = 32'h1;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      step();
      want    = 4'h0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      repeat (2) step();
      rd(7'h40, v); chk("clr_collide", v, 32'h0);

      // Saturation
      want = 4'b0001;
      repeat (20) step();
      want = 4'h0;
      repeat (2) step();
      rd(7'h40, v); chk("cnt_sat", v, 32'd15);

      // Byte strobes and unmapped read
      wr(7'h00, 32'h0, 4'hF);
      wr(7'h00, 32'hFFFFFFFF, 4'h1);
      rd(7'h00, v); chk("wstrb_ch_en", v, 32'h0F);
      wr(7'h00, 32'h0, 4'h2);
      rd(7'h00, v); chk("wstrb_skip", v, 32'h0F);
      rd(7'h30, v); chk("unmapped", v, 32'h0);

      // B held with bready low blocks the next write
      bready  = 1'b0;
      awaddr  = 7'h00;
      wdata   = 32'h1;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      step();
      wdata = 32'h3;
      repeat (4) step();
      chk("b_held", bvalid, 1'b1);
      bready = 1'b1;
      step();
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      repeat (2) step();
      rd(7'h00, v); chk("ch_en_2nd", v, 32'h3);
      wr(7'h00, 32'hF, 4'hF);

      // Reset in the middle of traffic, with a held output
      mready = 1'b0;
      want   = 4'hF;
      repeat (2) step();
      ARESET = 1'b1;
      repeat (3) step();
      ARESET = 1'b0;
      want   = 4'h0;
      chk("rst_mvalid", mvalid, 1'b0);
      chk("rst_mdata", mdata, 128'h0);
      chk("rst_bvalid", bvalid, 1'b0);
      step();
      rd(7'h00, v); chk("rst2_ch_en", v, 32'h0000000F);
      rd(7'h0C, v); chk("rst2_version", v, 32'h00020004);
      rd(7'h44, v); chk("rst2_cnt1", v, 32'h0);
      rd(7'h04, v); chk("rst2_last", v, 32'h3);
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
